wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/levenshtein_pkg.sv | 33 +++
 rtl/wb_timeout_counter.sv | 43 ++++
 rtl/wb_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_wb_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/levenshtein_pkg.sv
`default_nettype none
// ============================================================================
// Module      : levenshtein_pkg
// Description : Types and constants shared by the Wishbone arbiter slice.
//               arb_state_t  - arbiter FSM state (IDLE / OWN0 / OWN1)
//               GRANT_*      - one-hot grant encodings driven on grant_o
//               grant_of()   - maps an arbiter state to its grant encoding
// Revision    : 1.0 - initial release
// ============================================================================
package levenshtein_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  function automatic logic [1:0] grant_of(input arb_state_t state);
    logic [1:0] grant;
    case (state)
      OWN0:    grant = GRANT_M0;
      OWN1:    grant = GRANT_M1;
      default: grant = GRANT_NONE;
    endcase
    return grant;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : wb_timeout_counter
// Description : 8-bit stall counter. Counts cycles with cnt_en_i high and
//               raises expire_o for one cycle once TIMEOUT_CYCLES stalled
//               cycles have accumulated; the counter then restarts from 0.
// Ports       : clk_i     - clock
//               rst_ni    - asynchronous active-low reset
//               cnt_en_i  - a stalled strobe cycle (count it)
//               clr_i     - response seen or ownership change (restart)
//               expire_o  - single-cycle timeout pulse
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic cnt_en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam logic [7:0] c_limit = 8'(TIMEOUT_CYCLES);

  logic [7:0] r_count;

  // Expiry is decoded from the registered count only, so the strobe mask
  // in the arbiter never forms a combinational loop through this block.
  assign expire_o = (r_count == c_limit);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= 8'd0;
    end else if (clr_i || expire_o) begin
      r_count <= 8'd0;
    end else if (cnt_en_i) begin
      r_count <= r_count + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Two-master / one-slave Wishbone arbiter with round-robin
//               selection and bus lock while the owner holds cyc.
//               m0 = host bridge, m1 = Levenshtein engine, s = SRAM/SPI.
// Ports       : clk_i, rst_ni          - clock, async active-low reset
//               m0_* / m1_*            - master request inputs and responses
//               s_*                    - shared slave request / responses
//               grant_o                - one-hot owner, 2'b00 when idle
// Config      : WB_ARBITER_TIMEOUT_EN  - when defined, a stalled strobe is
//               terminated with err after TIMEOUT_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
  import levenshtein_pkg::*;
#(
  parameter int ADDR_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // master 0
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [7:0]            m0_dat_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rty_o,
  output logic [7:0]            m0_dat_o,
  // master 1
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [7:0]            m1_dat_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rty_o,
  output logic [7:0]            m1_dat_o,
  // shared slave
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [7:0]            s_dat_o,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i,
  input  logic [7:0]            s_dat_i,
  // status
  output logic [1:0]            grant_o
);

  arb_state_t r_state;
  arb_state_t w_state_next;
  logic       r_last_m1;      // 1: master 1 was granted most recently
  logic       w_owner_stb;
  logic       w_any_rsp;
  logic       w_expire;

  // --------------------------------------------------------------------------
  // State register and round-robin pointer. Reset leaves r_last_m1 set so
  // master 0 wins the first contended arbitration.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_last_m1 <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (w_state_next == OWN0) begin
        r_last_m1 <= 1'b0;
      end else if (w_state_next == OWN1) begin
        r_last_m1 <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. An owner keeps the bus for as long as its cyc is high;
  // on release the bus passes straight to a waiting master without IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_state_next = r_last_m1 ? OWN0 : OWN1;
        end else if (m0_cyc_i) begin
          w_state_next = OWN0;
        end else if (m1_cyc_i) begin
          w_state_next = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          w_state_next = m1_cyc_i ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          w_state_next = m0_cyc_i ? OWN0 : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_any_rsp = s_ack_i | s_err_i | s_rty_i;

  // --------------------------------------------------------------------------
  // Optional stall timeout
  // --------------------------------------------------------------------------
`ifdef WB_ARBITER_TIMEOUT_EN
  wb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .cnt_en_i (w_owner_stb & ~w_any_rsp),
    .clr_i    (w_any_rsp | (w_state_next != r_state)),
    .expire_o (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Request mux and response routing. Responses are qualified with the
  // owner's live cyc, so a response landing in the cycle the owner drops cyc
  // is discarded rather than leaking to the next owner.
  // --------------------------------------------------------------------------
  always_comb begin
    w_owner_stb = 1'b0;
    s_cyc_o     = 1'b0;
    s_we_o      = 1'b0;
    s_adr_o     = '0;
    s_dat_o     = 8'd0;
    m0_ack_o    = 1'b0;
    m0_err_o    = 1'b0;
    m0_rty_o    = 1'b0;
    m1_ack_o    = 1'b0;
    m1_err_o    = 1'b0;
    m1_rty_o    = 1'b0;
    case (r_state)
      OWN0: begin
        s_cyc_o     = m0_cyc_i;
        w_owner_stb = m0_stb_i;
        s_we_o      = m0_we_i;
        s_adr_o     = m0_adr_i;
        s_dat_o     = m0_dat_i;
        m0_ack_o    = m0_cyc_i & s_ack_i;
        m0_err_o    = m0_cyc_i & (s_err_i | w_expire);
        m0_rty_o    = m0_cyc_i & s_rty_i;
      end
      OWN1: begin
        s_cyc_o     = m1_cyc_i;
        w_owner_stb = m1_stb_i;
        s_we_o      = m1_we_i;
        s_adr_o     = m1_adr_i;
        s_dat_o     = m1_dat_i;
        m1_ack_o    = m1_cyc_i & s_ack_i;
        m1_err_o    = m1_cyc_i & (s_err_i | w_expire);
        m1_rty_o    = m1_cyc_i & s_rty_i;
      end
      default: ;
    endcase
  end

  // The timeout cycle withdraws the strobe so the slave sees no access while
  // the master is being told the transfer failed.
  assign s_stb_o  = w_owner_stb & ~w_expire;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign grant_o  = grant_of(r_state);

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Self-checking bench for wb_arbiter. Expected master responses
//               are queued when the slave response is driven and compared
//               when a response pulse appears on either master port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  localparam logic [2:0] c_ack = 3'b100;
  localparam logic [2:0] c_err = 3'b010;
  localparam logic [2:0] c_rty = 3'b001;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [23:0] m0_adr_i;
  logic [7:0]  m0_dat_i;
  logic        m0_ack_o, m0_err_o, m0_rty_o;
  logic [7:0]  m0_dat_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [23:0] m1_adr_i;
  logic [7:0]  m1_dat_i;
  logic        m1_ack_o, m1_err_o, m1_rty_o;
  logic [7:0]  m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [23:0] s_adr_o;
  logic [7:0]  s_dat_o;
  logic        s_ack_i, s_err_i, s_rty_i;
  logic [7:0]  s_dat_i;
  logic [1:0]  grant_o;

  wb_arbiter #(
    .ADDR_WIDTH     (24),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i),
    .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i),
    .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o), .m0_rty_o (m0_rty_o),
    .m0_dat_o (m0_dat_o),
    .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i), .m1_we_i (m1_we_i),
    .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i),
    .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o), .m1_rty_o (m1_rty_o),
    .m1_dat_o (m1_dat_o),
    .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),  .s_we_o   (s_we_o),
    .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),
    .s_ack_i  (s_ack_i),  .s_err_i  (s_err_i),  .s_rty_i  (s_rty_i),
    .s_dat_i  (s_dat_i),
    .grant_o  (grant_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_compared   = 0;
  int          n_mismatched = 0;
  logic [13:0] sb_q[$];
  logic [13:0] w_rsp;

  assign w_rsp = {m1_ack_o, m1_err_o, m1_rty_o, m0_ack_o, m0_err_o, m0_rty_o, m0_dat_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Queue the response the owning master must see and drive it on the slave.
  task automatic slave_rsp(input bit owner_m1, input logic [2:0] kind, input logic [7:0] dat);
    {s_ack_i, s_err_i, s_rty_i} = kind;
    s_dat_i = dat;
    if (owner_m1) sb_q.push_back({kind, 3'b000, dat});
    else          sb_q.push_back({3'b000, kind, dat});
  endtask

  task automatic slave_idle();
    {s_ack_i, s_err_i, s_rty_i} = 3'b000;
  endtask

  // Response monitor: every master-side response pulse must match the head
  // of the scoreboard; a pulse with nothing queued is a stray response.
  always @(negedge clk_i) begin
    if (w_rsp[13:8] != 6'd0) begin
      if (sb_q.size() == 0) check("unexpected_rsp", 32'(w_rsp), 32'd0);
      else                  check("rsp", 32'(w_rsp), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int err_count;
    {m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i} = '0;
    {m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i} = '0;
    {s_ack_i, s_err_i, s_rty_i, s_dat_i} = '0;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_s_ctl", 32'({s_cyc_o, s_stb_o, s_we_o}), 32'd0);
    rst_ni = 1'b1;

    // Single m0 read, slave acks three cycles after the grant.
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 24'h800010;
    @(negedge clk_i);
    check("t1_latency_grant", 32'(grant_o), 32'd0);
    check("t1_latency_scyc", 32'(s_cyc_o), 32'd0);
    @(negedge clk_i);
    check("t1_grant", 32'(grant_o), 32'h1);
    check("t1_adr", 32'(s_adr_o), 32'h800010);
    check("t1_ctl", 32'({s_cyc_o, s_stb_o, s_we_o}), 32'b110);
    step(); step();
    slave_rsp(1'b0, c_ack, 8'h2A);
    @(negedge clk_i);
    check("t1_m1_ack", 32'(m1_ack_o), 32'd0);
    check("t1_m1_dat", 32'(m1_dat_o), 32'h2A);
    step();
    slave_idle();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step();
    @(negedge clk_i);
    check("t1_idle", 32'(grant_o), 32'd0);

    // Simultaneous requests after reset: m0 first, direct handoff to m1.
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 24'h800020;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 24'h000123; m1_dat_i = 8'hC3;
    step();
    slave_rsp(1'b0, c_ack, 8'h11);
    @(negedge clk_i);
    check("t2_first_grant", 32'(grant_o), 32'h1);
    check("t2_adr_m0", 32'(s_adr_o), 32'h800020);
    step();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    {s_ack_i, s_err_i, s_rty_i} = c_ack;   // arrives as owner drops cyc: must vanish
    s_dat_i = 8'h99;
    @(negedge clk_i);
    check("t2_drop_grant", 32'(grant_o), 32'h1);
    check("t2_drop_scyc", 32'(s_cyc_o), 32'd0);
    step();
    slave_idle();
    @(negedge clk_i);
    check("t2_handoff", 32'(grant_o), 32'h2);
    check("t2_m1_req", 32'({s_we_o, s_dat_o, s_adr_o}), 32'({1'b1, 8'hC3, 24'h000123}));
    step();
    slave_rsp(1'b1, c_ack, 8'h55);
    step();
    slave_idle();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
    step();
    @(negedge clk_i);
    check("t2_idle", 32'(grant_o), 32'd0);

    // m1 holds the bus for four beats while m0 keeps requesting.
    step();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 24'h000200;
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 24'h800040;
    for (int b = 0; b < 4; b++) begin
      step();
      slave_rsp(1'b1, c_ack, 8'(8'h40 + b));
      @(negedge clk_i);
      check("t3_lock_grant", 32'(grant_o), 32'h2);
      step();
      slave_idle();
    end
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step();
    @(negedge clk_i);
    check("t3_handoff", 32'(grant_o), 32'h1);

    // err and rty follow the same routing and timing as ack.
    step();
    slave_rsp(1'b0, c_err, 8'hE1);
    @(negedge clk_i);
    check("t3_m1_err", 32'(m1_err_o), 32'd0);
    step();
    slave_rsp(1'b0, c_rty, 8'hE2);
    @(negedge clk_i);
    check("t3_m1_rty", 32'(m1_rty_o), 32'd0);
    step();
    slave_idle();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step();

    // Reset while m1 awaits its ack.
    step();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    step();
    @(negedge clk_i);
    check("t4_grant", 32'(grant_o), 32'h2);
    #2 rst_ni = 1'b0;
    #1;
    check("t4_rst_grant", 32'(grant_o), 32'd0);
    check("t4_rst_s", 32'({s_cyc_o, s_stb_o}), 32'd0);
    {s_ack_i, s_err_i, s_rty_i} = c_ack;   // late ack: nobody may see it
    s_dat_i = 8'h77;
    #1;
    check("t4_no_ack", 32'({m0_ack_o, m1_ack_o}), 32'd0);
    step();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step();
    rst_ni = 1'b1;
    step(); step();
    slave_idle();
    s_dat_i = 8'h00;
    step();

    // Stalled slave.
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 24'h800050;
`ifdef WB_ARBITER_TIMEOUT_EN
    sb_q.push_back({3'b000, c_err, 8'h00});
    @(negedge clk_i);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk_i);
      check("t5_timeout_err", 32'(m0_err_o), 32'(i == 8));
      check("t5_stb_mask", 32'(s_stb_o), 32'(i != 8));
    end
`else
    err_count = 0;
    @(negedge clk_i);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_i);
      if (m0_err_o || m1_err_o) err_count++;
    end
    check("t5_no_timeout", 32'(err_count), 32'd0);
    check("t5_stb_held", 32'(s_stb_o), 32'd1);
`endif
    step();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step(); step();

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
